// File: rtl/bus_fabric.sv
// bus_fabric: routes one CPU load/store request at a time to one of NSLV
// memory-mapped slaves. Requests use a valid/ready handshake. Slaves may
// take several cycles to answer, and a watchdog ends an access that waits
// too long. A request that matches no region gets an error response. A
// saturating counter records how many error responses have been sent.
module bus_fabric #(
    parameter int                     XLEN    = 64,
    parameter int                     NSLV    = 4,
    parameter logic [NSLV*XLEN-1:0]   BASE    = '0,
    parameter logic [NSLV*XLEN-1:0]   MASK    = '0,
    parameter int                     TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [XLEN/8-1:0]      req_bytes,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   resp_valid,
    output logic [XLEN-1:0]        resp_rdata,
    output logic                   resp_error,
    output logic [NSLV-1:0]        s_cen,
    output logic                   s_wr,
    output logic [XLEN/8-1:0]      s_strb,
    output logic [XLEN-1:0]        s_addr,
    output logic [XLEN-1:0]        s_wdata,
    input  logic [NSLV-1:0]        s_ready,
    input  logic [NSLV*XLEN-1:0]   s_rdata,
    input  logic [NSLV-1:0]        s_error,
    output logic [15:0]            err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The counter value on the last cycle an access may still wait.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t             state;
    state_t             next_state;
    logic [15:0]        wait_cnt;
    logic               hit;
    logic [NSLV-1:0]    hit_sel;
    logic               sel_ready;
    logic               sel_error;
    logic [XLEN-1:0]    sel_rdata;
    logic               timeout;

    // Address decode. The loop runs from the highest index down, so the
    // lowest-index matching slave is the one that remains selected.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((req_addr & MASK[i*XLEN +: XLEN]) == BASE[i*XLEN +: XLEN]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    // Look only at the completion, error and read data of the selected slave.
    always_comb begin
        sel_ready = |(s_ready & s_cen);
        sel_error = |(s_error & s_cen);
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | (s_rdata[i*XLEN +: XLEN] & {XLEN{s_cen[i]}});
        end
    end

    assign timeout = (wait_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = hit ? ACCESS : RESP;
            end
            ACCESS: begin
                if (sel_ready || timeout) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request, drive the slave select, count wait cycles,
    // build the response and keep the error count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_cen      <= '0;
            s_wr       <= 1'b0;
            s_strb     <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        s_wr     <= req_wr;
                        s_strb   <= req_bytes;
                        s_addr   <= req_addr;
                        s_wdata  <= req_wdata;
                        wait_cnt <= '0;
                        if (hit) begin
                            s_cen <= hit_sel;
                        end else begin
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        s_cen      <= '0;
                        resp_error <= sel_error;
                        resp_rdata <= (s_wr || sel_error) ? '0 : sel_rdata;
                    end else if (timeout) begin
                        s_cen      <= '0;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_error && (err_count != 16'hFFFF))
                        err_count <= err_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed testbench for bus_fabric. It uses four slave regions, and the
// region for slave 2 overlaps the region for slave 0. TIMEOUT is set to 8.
module tb_bus_fabric;

    localparam int XLEN = 64;
    localparam int NSLV = 4;
    localparam logic [63:0] M12 = 64'hFFFF_FFFF_FFFF_F000;
    localparam logic [63:0] M8  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [NSLV*XLEN-1:0] BASE_P = {64'h4000, 64'h1000, 64'h2000, 64'h1000};
    localparam logic [NSLV*XLEN-1:0] MASK_P = {M12, M8, M12, M12};

    logic                  clk;
    logic                  rstn;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [XLEN/8-1:0]     req_bytes;
    logic [XLEN-1:0]       req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_error;
    logic [NSLV-1:0]       s_cen;
    logic                  s_wr;
    logic [XLEN/8-1:0]     s_strb;
    logic [XLEN-1:0]       s_addr;
    logic [XLEN-1:0]       s_wdata;
    logic [NSLV-1:0]       s_ready;
    logic [NSLV*XLEN-1:0]  s_rdata;
    logic [NSLV-1:0]       s_error;
    logic [15:0]           err_count;

    int checks;
    int failures;
    int cen_cycles;

    bus_fabric #(
        .XLEN(XLEN), .NSLV(NSLV), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bytes(req_bytes), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .s_cen(s_cen), .s_wr(s_wr), .s_strb(s_strb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_error(s_error),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each comparison is an immediate assertion. A failed one is counted and reported.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one request across a single posedge. On return the bench sits
    // at the negedge of the first cycle after the accept.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] strb);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_bytes = strb;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_bytes = '0;
        req_addr  = '0;
        req_wdata = '0;
        s_ready   = '0;
        s_error   = '0;
        s_rdata   = {64'h3333, 64'h2222, 64'hDEAD_BEEF, 64'h1111};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_s_cen", 64'(s_cen), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
        checkOutput("rst_s_addr", s_addr, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Read hit on slave 1 that completes at once.
        s_ready = 4'b0010;
        applyStimulus(1'b0, 64'h2010, 64'h0, 8'hFF);
        checkOutput("rd_s_cen", 64'(s_cen), 64'h2);
        checkOutput("rd_req_ready_busy", 64'(req_ready), 64'd0);
        checkOutput("rd_resp_valid_early", 64'(resp_valid), 64'd0);
        checkOutput("rd_s_addr", s_addr, 64'h2010);
        @(negedge clk);
        checkOutput("rd_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("rd_resp_rdata", resp_rdata, 64'hDEAD_BEEF);
        checkOutput("rd_resp_error", 64'(resp_error), 64'd0);
        checkOutput("rd_s_cen_drop", 64'(s_cen), 64'd0);
        s_ready = '0;
        @(negedge clk);
        checkOutput("rd_resp_pulse", 64'(resp_valid), 64'd0);
        checkOutput("rd_req_ready_back", 64'(req_ready), 64'd1);

        // Write to slave 0 with three wait cycles. The error from slave 1 is ignored because slave 1 is not selected.
        s_error = 4'b0010;
        applyStimulus(1'b1, 64'h1800, 64'hCAFE, 8'h0F);
        checkOutput("wr_s_strb", 64'(s_strb), 64'h0F);
        checkOutput("wr_s_wr", 64'(s_wr), 64'd1);
        checkOutput("wr_s_wdata", s_wdata, 64'hCAFE);
        checkOutput("wr_s_cen_c1", 64'(s_cen), 64'h1);
        @(negedge clk);
        checkOutput("wr_s_cen_c2", 64'(s_cen), 64'h1);
        @(negedge clk);
        checkOutput("wr_s_cen_c3", 64'(s_cen), 64'h1);
        @(negedge clk);
        checkOutput("wr_s_cen_c4", 64'(s_cen), 64'h1);
        checkOutput("wr_no_resp_yet", 64'(resp_valid), 64'd0);
        s_ready = 4'b0001;
        @(negedge clk);
        s_ready = '0;
        s_error = '0;
        checkOutput("wr_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("wr_resp_rdata", resp_rdata, 64'd0);
        checkOutput("wr_resp_error", 64'(resp_error), 64'd0);
        checkOutput("wr_s_cen_drop", 64'(s_cen), 64'd0);
        @(negedge clk);

        // Decode miss at address 0.
        applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF);
        checkOutput("miss_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("miss_resp_error", 64'(resp_error), 64'd1);
        checkOutput("miss_resp_rdata", resp_rdata, 64'd0);
        checkOutput("miss_s_cen", 64'(s_cen), 64'd0);
        @(negedge clk);
        checkOutput("miss_err_count", 64'(err_count), 64'd1);

        // Timeout on slave 3, which never becomes ready. The count of s_cen cycles is bounded.
        applyStimulus(1'b0, 64'h4000, 64'h0, 8'hFF);
        cen_cycles = 0;
        while (s_cen == 4'b1000 && cen_cycles < 20) begin
            cen_cycles++;
            @(negedge clk);
        end
        checkOutput("to_cen_cycles", 64'(cen_cycles), 64'd8);
        checkOutput("to_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("to_resp_error", 64'(resp_error), 64'd1);
        checkOutput("to_resp_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        checkOutput("to_err_count", 64'(err_count), 64'd2);

        // Overlapping regions. Slave 0 wins, and ready pulses from slave 2 are ignored.
        s_ready = 4'b0100;
        applyStimulus(1'b0, 64'h1010, 64'h0, 8'hFF);
        checkOutput("ovl_s_cen_c1", 64'(s_cen), 64'h1);
        @(negedge clk);
        checkOutput("ovl_s_cen_c2", 64'(s_cen), 64'h1);
        checkOutput("ovl_ignore_ready", 64'(resp_valid), 64'd0);
        s_ready = 4'b0001;
        @(negedge clk);
        s_ready = '0;
        checkOutput("ovl_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("ovl_resp_rdata", resp_rdata, 64'h1111);
        checkOutput("ovl_resp_error", 64'(resp_error), 64'd0);
        @(negedge clk);

        // Slave error reported by slave 3 on a write.
        s_ready = 4'b1000;
        s_error = 4'b1000;
        applyStimulus(1'b1, 64'h4008, 64'h55, 8'hFF);
        @(negedge clk);
        s_ready = '0;
        s_error = '0;
        checkOutput("serr_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("serr_resp_error", 64'(resp_error), 64'd1);
        @(negedge clk);
        checkOutput("serr_err_count", 64'(err_count), 64'd3);

        // Reset in the middle of an access. The transaction is dropped with no response.
        applyStimulus(1'b0, 64'h2000, 64'h0, 8'hFF);
        checkOutput("mrst_s_cen_before", 64'(s_cen), 64'h2);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("mrst_s_cen", 64'(s_cen), 64'd0);
        checkOutput("mrst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("mrst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("mrst_err_count", 64'(err_count), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("mrst_no_resp", 64'(resp_valid), 64'd0);

        // Saturation. Preload the counter just below its maximum, then send two misses.
        force dut.err_count = 16'hFFFE;
        @(negedge clk);
        release dut.err_count;
        applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF);
        @(negedge clk);
        checkOutput("sat_reach_max", 64'(err_count), 64'hFFFF);
        applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF);
        checkOutput("sat_miss_resp", 64'(resp_error), 64'd1);
        @(negedge clk);
        checkOutput("sat_hold_max", 64'(err_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
